alu_axi_lite_master: RTL and testbench

//  AXI-Lite master that drives the 8-bit ALU AXI-Lite slave directly downstream.

---
 rtl/alu_axi_pkg.sv | 19 +
 rtl/alu_axi_lite_master_if.sv | 33 +++
 rtl/alu_axi_lite_wr_beat.sv | 29 ++
 rtl/alu_axi_lite_master.sv | 205 ++++++++++++++++++++
 tb/tb_alu_axi_lite_master.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_axi_pkg.sv
// alu_axi_pkg: ALU slave register map, response codes, master FSM states and beat helpers
package alu_axi_pkg;
  localparam logic [3:0] ADDR_OPERAND_A = 4'h0;
  localparam logic [3:0] ADDR_OPERAND_B = 4'h4;
  localparam logic [3:0] ADDR_CONTROL   = 4'h8;
  localparam logic [3:0] ADDR_RESULT    = 4'hC;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam int         CTRL_ENABLE_BIT = 3;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;
  function automatic logic [3:0] beat_off(input logic [1:0] beat);
    return beat == 2'd0 ? ADDR_OPERAND_A : beat == 2'd1 ? ADDR_OPERAND_B : ADDR_CONTROL;
  endfunction
  function automatic logic [7:0] beat_byte(input logic [1:0] beat, input logic [7:0] a, b, input logic [2:0] op);
    logic [7:0] ctrl;
    ctrl = {5'b0, op};
    ctrl[CTRL_ENABLE_BIT] = 1'b1;
    return beat == 2'd0 ? a : beat == 2'd1 ? b : ctrl;
  endfunction
endpackage

// File: rtl/alu_axi_lite_master_if.sv
// alu_axi_lite_master_if: AXI-Lite bus (AW/W/B/AR/R) with master and slave modports
interface alu_axi_lite_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/alu_axi_lite_wr_beat.sv
// alu_axi_lite_wr_beat: raises awvalid/wvalid together on start, drops each on its own ready, flags done when both closed
module alu_axi_lite_wr_beat (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic done_o
);
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  always_comb begin
    awvalid_d = start_i | (awvalid_q & ~awready_i);
    wvalid_d  = start_i | (wvalid_q & ~wready_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign done_o    = (~awvalid_q | awready_i) & (~wvalid_q | wready_i);
endmodule

// File: rtl/alu_axi_lite_master.sv
// alu_axi_lite_master: takes {a,b,opcode} on cmd_*, writes OPERAND_A/B and CONTROL, reads RESULT, returns it on rsp_*; ALU_MST_OPCACHE_EN skips unchanged operand writes
module alu_axi_lite_master
  import alu_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_opcode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_error,
  alu_axi_lite_master_if.master m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, src_a, src_b;
  logic [2:0] op_q, op_d, src_op;
  logic [1:0] beat_q, beat_d, nxt_beat;
  logic err_q, err_d, bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, start_wr, wr_done;
  logic [15:0] result_q, result_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic hit_a_cmd, hit_b_cmd, hit_b_q, b_bad, r_bad;
  logic unused_rdata;
  assign b_bad = m_axi.bresp != RESP_OKAY;
  assign r_bad = m_axi.rresp != RESP_OKAY;
  assign unused_rdata = ^m_axi.rdata[DW-1:16];
`ifdef ALU_MST_OPCACHE_EN
  logic [7:0] ca_q, cb_q;
  logic va_q, vb_q;
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else if (state_q == WB && m_axi.bvalid) begin
      if (b_bad) begin
        va_q <= 1'b0;
        vb_q <= 1'b0;
      end else if (beat_q == 2'd0) begin
        ca_q <= a_q;
        va_q <= 1'b1;
      end else if (beat_q == 2'd1) begin
        cb_q <= b_q;
        vb_q <= 1'b1;
      end
    end
  end
  assign hit_a_cmd = va_q && ca_q == cmd_a;
  assign hit_b_cmd = vb_q && cb_q == cmd_b;
  // a bad bresp on beat 0 flushes the cache this same cycle, so it cannot justify skipping beat 1
  assign hit_b_q   = vb_q && cb_q == b_q && !b_bad;
`else
  assign hit_a_cmd = 1'b0;
  assign hit_b_cmd = 1'b0;
  assign hit_b_q   = 1'b0;
`endif
  alu_axi_lite_wr_beat u_wr_beat (
    .clk       (m_axi_aclk),
    .rst       (m_axi_areset),
    .start_i   (start_wr),
    .awready_i (m_axi.awready),
    .wready_i  (m_axi.wready),
    .awvalid_o (m_axi.awvalid),
    .wvalid_o  (m_axi.wvalid),
    .done_o    (wr_done)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    beat_d = beat_q;
    err_d = err_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bready_d = bready_q;
    araddr_d = araddr_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    rsp_valid_d = rsp_valid_q;
    result_d = result_q;
    rsp_err_d = rsp_err_q;
    start_wr = 1'b0;
    nxt_beat = 2'd0;
    src_a = a_q;
    src_b = b_q;
    src_op = op_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d = cmd_a;
        b_d = cmd_b;
        op_d = cmd_opcode;
        src_a = cmd_a;
        src_b = cmd_b;
        src_op = cmd_opcode;
        err_d = 1'b0;
        nxt_beat = hit_a_cmd ? (hit_b_cmd ? 2'd2 : 2'd1) : 2'd0;
        start_wr = 1'b1;
      end
      WR: if (wr_done) begin
        bready_d = 1'b1;
        state_d = WB;
      end
      WB: if (m_axi.bvalid) begin
        bready_d = 1'b0;
        err_d = err_q | b_bad;
        if (beat_q == 2'd2) begin
          arvalid_d = 1'b1;
          araddr_d = BASE_ADDR + AW'(ADDR_RESULT);
          state_d = RA;
        end else begin
          nxt_beat = (beat_q == 2'd0 && !hit_b_q) ? 2'd1 : 2'd2;
          start_wr = 1'b1;
        end
      end
      RA: if (m_axi.arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD;
      end
      RD: if (m_axi.rvalid) begin
        rready_d = 1'b0;
        result_d = m_axi.rdata[15:0];
        err_d = err_q | r_bad;
        rsp_err_d = err_q | r_bad;
        rsp_valid_d = 1'b1;
        state_d = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start_wr) begin
      beat_d = nxt_beat;
      awaddr_d = BASE_ADDR + AW'(beat_off(nxt_beat));
      wdata_d = DW'(beat_byte(nxt_beat, src_a, src_b, src_op));
      wstrb_d = (DW/8)'(1);
      state_d = WR;
    end
  end
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bready_q <= 1'b0;
      araddr_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      result_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      beat_q <= beat_d;
      err_q <= err_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bready_q <= bready_d;
      araddr_q <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      result_q <= result_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_error = rsp_err_q;
  assign m_axi.awaddr = awaddr_q;
  assign m_axi.awprot = 3'b000;
  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = wstrb_q;
  assign m_axi.bready = bready_q;
  assign m_axi.araddr = araddr_q;
  assign m_axi.arprot = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready = rready_q;
endmodule

// File: tb/tb_alu_axi_lite_master.sv
// tb_alu_axi_lite_master: directed bench with a wait-state/error-injecting ALU slave model
module tb_alu_axi_lite_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_opcode = '0;
  logic cmd_ready, rsp_valid, rsp_error;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  int n_chk = 0, n_pass = 0;
  int aw_wait[64], w_wait[64];
  logic [1:0] b_err[64];
  int b_wait = 0;
  int aw_n = 0, w_n = 0, b_n = 0, wr_n = 0, rd_n = 0;
  int aw_hi[64] = '{default: 0};
  int w_hi[64] = '{default: 0};
  logic [3:0] wr_addr[64], rd_addr[64];
  logic [31:0] wr_data[64];
  logic [31:0] regs[4] = '{default: 0};
  logic [3:0] awq[$];
  logic [31:0] wq[$];
  logic [3:0] wa;
  logic [31:0] wd;
  int aw_cnt = 0, w_cnt = 0, bw_cnt = 0, b_pend = 0, r_pend = 0;
  logic b_fire = 1'b0, r_fire = 1'b0;
  always #5 clk = ~clk;
  alu_axi_lite_master_if #(.ADDR_W(4), .DATA_W(32)) m ();
  alu_axi_lite_master #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .BASE_ADDR(4'h0)) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_opcode   (cmd_opcode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_error    (rsp_error),
    .m_axi        (m)
  );
  function automatic logic [15:0] alu(input logic [7:0] a, b, input logic [2:0] op);
    logic [15:0] x, y;
    x = {8'h0, a};
    y = {8'h0, b};
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x * y;
      3'd6: return x << b[2:0];
      default: return x;
    endcase
  endfunction
  // slave decides its readies at negedge; a ready set here together with a visible valid fires on the next posedge
  always @(negedge clk) begin
    if (rst) begin
      m.awready = 1'b0;
      m.wready = 1'b0;
      m.bvalid = 1'b0;
      m.bresp = 2'b00;
      m.arready = 1'b0;
      m.rvalid = 1'b0;
      m.rresp = 2'b00;
      m.rdata = '0;
      awq.delete();
      wq.delete();
      aw_cnt = 0;
      w_cnt = 0;
      bw_cnt = 0;
      b_pend = 0;
      r_pend = 0;
      b_fire = 1'b0;
      r_fire = 1'b0;
    end else begin
      while (awq.size() > 0 && wq.size() > 0) begin
        wa = awq.pop_front();
        wd = wq.pop_front();
        regs[wa[3:2]] = wd;
        wr_addr[wr_n] = wa;
        wr_data[wr_n] = wd;
        wr_n++;
        b_pend++;
      end
      if (b_fire) begin
        m.bvalid = 1'b0;
        b_fire = 1'b0;
      end else if (!m.bvalid && b_pend > 0) begin
        if (bw_cnt >= b_wait) begin
          m.bvalid = 1'b1;
          m.bresp = b_err[b_n];
          b_n++;
          b_pend--;
          bw_cnt = 0;
        end else bw_cnt++;
      end
      if (m.bvalid && m.bready) b_fire = 1'b1;
      if (r_fire) begin
        m.rvalid = 1'b0;
        r_fire = 1'b0;
      end else if (!m.rvalid && r_pend > 0) begin
        m.rvalid = 1'b1;
        m.rdata = {16'hA5A5, regs[2][3] ? alu(regs[0][7:0], regs[1][7:0], regs[2][2:0]) : 16'h0};
        m.rresp = 2'b00;
        r_pend--;
      end
      if (m.rvalid && m.rready) r_fire = 1'b1;
      m.awready = 1'b0;
      if (m.awvalid) begin
        aw_hi[aw_n]++;
        if (aw_cnt >= aw_wait[aw_n]) begin
          m.awready = 1'b1;
          awq.push_back(m.awaddr);
          aw_cnt = 0;
          aw_n++;
        end else aw_cnt++;
      end
      m.wready = 1'b0;
      if (m.wvalid) begin
        w_hi[w_n]++;
        if (w_cnt >= w_wait[w_n]) begin
          m.wready = 1'b1;
          wq.push_back(m.wdata);
          w_cnt = 0;
          w_n++;
        end else w_cnt++;
      end
      m.arready = 1'b0;
      if (m.arvalid) begin
        m.arready = 1'b1;
        rd_addr[rd_n] = m.araddr;
        rd_n++;
        r_pend++;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic run_cmd(input string tag, input logic [7:0] a, b, input logic [2:0] op, input int hold,
                         input logic [15:0] er, input logic ee);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_opcode = op;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_result"}, rsp_result, er);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
      @(negedge clk);
    end
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_error"}, rsp_error, ee);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 0);
    check({tag, "_idle"}, cmd_ready, 1);
  endtask
  initial begin
    int wb, rb, ab, xb, n;
    for (int i = 0; i < 64; i++) begin
      aw_wait[i] = 0;
      w_wait[i] = 0;
      b_err[i] = 2'b00;
    end
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_awvalid", m.awvalid, 0);
    check("rst_wvalid", m.wvalid, 0);
    check("rst_bready", m.bready, 0);
    check("rst_arvalid", m.arvalid, 0);
    check("rst_rready", m.rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_awaddr", m.awaddr, 0);
    check("rst_araddr", m.araddr, 0);
    check("rst_wdata", m.wdata, 0);
    check("rst_wstrb", m.wstrb, 0);
    check("rst_prot", {m.awprot, m.arprot}, 0);
    rst = 1'b0;
    wb = wr_n;
    rb = rd_n;
    run_cmd("basic", 8'h12, 8'h34, 3'd0, 0, 16'h0046, 1'b0);
    check("basic_nwr", wr_n - wb, 3);
    check("basic_w0", {wr_addr[wb], wr_data[wb]}, {4'h0, 32'h12});
    check("basic_w1", {wr_addr[wb+1], wr_data[wb+1]}, {4'h4, 32'h34});
    check("basic_w2", {wr_addr[wb+2], wr_data[wb+2]}, {4'h8, 32'h08});
    check("basic_nrd", rd_n - rb, 1);
    check("basic_raddr", rd_addr[rb], 4'hC);
    wb = wr_n;
    ab = aw_n;
    xb = w_n;
    aw_wait[ab+1] = 3;
    w_wait[xb+1] = 1;
    run_cmd("stall", 8'h20, 8'h03, 3'd1, 0, 16'h001D, 1'b0);
    check("stall_aw_hold", aw_hi[ab+1], 4);
    check("stall_w_hold", w_hi[xb+1], 2);
    check("stall_w1", {wr_addr[wb+1], wr_data[wb+1]}, {4'h4, 32'h03});
    check("stall_w2", {wr_addr[wb+2], wr_data[wb+2]}, {4'h8, 32'h09});
    wb = wr_n;
    rb = rd_n;
    b_err[b_n] = 2'b10;
    run_cmd("err", 8'h0F, 8'h0F, 3'd2, 0, 16'h000F, 1'b1);
    check("err_nwr", wr_n - wb, 3);
    check("err_nrd", rd_n - rb, 1);
    run_cmd("bp", 8'h10, 8'h10, 3'd5, 5, 16'h0100, 1'b0);
    b_wait = 20;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 8'h11;
    cmd_b = 8'h22;
    cmd_opcode = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m.bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_wb", m.bready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_awvalid", m.awvalid, 0);
    check("mid_wvalid", m.wvalid, 0);
    check("mid_arvalid", m.arvalid, 0);
    check("mid_bready", m.bready, 0);
    check("mid_rready", m.rready, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    b_wait = 0;
    repeat (5) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
    end
    run_cmd("recover", 8'h12, 8'h34, 3'd4, 0, 16'h0026, 1'b0);
    run_cmd("oc1", 8'h05, 8'h07, 3'd1, 0, 16'hFFFE, 1'b0);
    wb = wr_n;
    rb = rd_n;
    run_cmd("oc2", 8'h05, 8'h07, 3'd2, 0, 16'h0005, 1'b0);
    check("oc2_nrd", rd_n - rb, 1);
`ifdef ALU_MST_OPCACHE_EN
    check("oc2_nwr", wr_n - wb, 1);
    check("oc2_ctrl", {wr_addr[wb], wr_data[wb]}, {4'h8, 32'h0A});
`else
    check("oc2_nwr", wr_n - wb, 3);
    check("oc2_ctrl", {wr_addr[wb+2], wr_data[wb+2]}, {4'h8, 32'h0A});
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
